// File: rtl/mem_stage.sv
// mem_stage: MyProc2 memory-access stage. Registers each executed instruction and
// performs single- or double-beat data-memory accesses over a req/ack port.
module mem_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] Addr_in,
  output logic             IsStall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic [WIDTH-1:0] LMD,
  output logic [WIDTH-1:0] LMD_hi,
  output logic             valid_out,
  output logic             fault_out
);

  localparam logic [5:0] OP_LW = 6'h20;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LD = 6'h22;
  localparam logic [5:0] OP_SW = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SD = 6'h2A;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1} state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

  function automatic logic is_half(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_SH);
  endfunction

  function automatic logic is_double(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_SD);
  endfunction

  // Halfwords need even addresses; words and doublewords need word alignment.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    if (is_half(op)) return a[0];
    return a != 2'b00;
  endfunction

  function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] d, input logic sel);
    logic signed [15:0] h;
    h = sel ? $signed(d[31:16]) : $signed(d[15:0]);
    return {{(WIDTH-16){h[15]}}, h};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_ir;
  logic [WIDTH-3:0] r_pc;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_lmd;
  logic [WIDTH-1:0] r_lmd_hi;
  logic             r_valid;
  logic             r_fault;

  logic [5:0]       w_in_op;
  logic [5:0]       w_cur_op;
  logic             w_in_mem;
  logic             w_in_mis;
  logic             w_cur_ld;
  logic             w_cur_st;
  logic             w_cur_half;
  logic             w_cur_dbl;
  logic             w_done;
  logic [WIDTH-1:0] w_base;

  assign w_in_op    = IR_in[31:26];
  assign w_cur_op   = r_ir[31:26];
  assign w_in_mem   = is_load(w_in_op) || is_store(w_in_op);
  assign w_in_mis   = misaligned(w_in_op, Addr_in[1:0]);
  assign w_cur_ld   = is_load(w_cur_op);
  assign w_cur_st   = is_store(w_cur_op);
  assign w_cur_half = is_half(w_cur_op);
  assign w_cur_dbl  = is_double(w_cur_op);
  assign w_base     = {r_addr[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; w_done marks the edge that retires an access.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_in_mem && !w_in_mis) w_state_nxt = S_ACC0;
      end
      S_ACC0: begin
        if (mem_ack) begin
          if (w_cur_dbl) begin
            w_state_nxt = S_ACC1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      S_ACC1: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory port decoded only from registered state, so it holds steady until ack.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    case (r_state)
      S_ACC0: begin
        mem_req  = 1'b1;
        mem_we   = w_cur_st;
        mem_addr = w_base;
        if (w_cur_half) mem_be = r_addr[1] ? 4'b1100 : 4'b0011;
        else            mem_be = 4'b1111;
        if (w_cur_st) mem_wdata = w_cur_half ? {r_z[15:0], r_z[15:0]} : r_z;
      end
      S_ACC1: begin
        mem_req  = 1'b1;
        mem_we   = w_cur_st;
        mem_addr = w_base + WIDTH'(4);
        mem_be   = 4'b1111;
        if (w_cur_st) mem_wdata = {WIDTH{r_z[WIDTH-1]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir     <= '0;
      r_pc     <= '0;
      r_z      <= '0;
      r_addr   <= '0;
      r_lmd    <= '0;
      r_lmd_hi <= '0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ir     <= IR_in;
          r_pc     <= PC_in;
          r_z      <= Z_in;
          r_addr   <= Addr_in;
          r_lmd    <= '0;
          r_lmd_hi <= '0;
          if (!w_in_mem) begin
            r_valid <= 1'b1;
          end else if (w_in_mis) begin
            r_valid <= 1'b1;
            r_fault <= 1'b1;
          end
        end
        S_ACC0: begin
          if (mem_ack) begin
            if (w_cur_ld) r_lmd <= w_cur_half ? sext_half(mem_rdata, r_addr[1]) : mem_rdata;
            r_valid <= w_done;
          end
        end
        S_ACC1: begin
          if (mem_ack) begin
            if (w_cur_ld) r_lmd_hi <= mem_rdata;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign IsStall   = (r_state == S_ACC0) || (r_state == S_ACC1);
  assign IR_out    = r_ir;
  assign PC_out    = r_pc;
  assign Z_out     = r_z;
  assign LMD       = r_lmd;
  assign LMD_hi    = r_lmd_hi;
  assign valid_out = r_valid;
  assign fault_out = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: retired instructions are checked against a
// scoreboard queue filled as each instruction is driven.
module tb_mem_stage;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_LW   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LD   = 6'h22;
  localparam logic [5:0] OP_SW   = 6'h28;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SD   = 6'h2A;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR_in;
  logic [29:0] PC_in;
  logic [31:0] Z_in;
  logic [31:0] Addr_in;
  logic        IsStall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] IR_out;
  logic [29:0] PC_out;
  logic [31:0] Z_out;
  logic [31:0] LMD;
  logic [31:0] LMD_hi;
  logic        valid_out;
  logic        fault_out;

  typedef struct packed {
    logic [31:0] ir;
    logic [29:0] pc;
    logic [31:0] z;
    logic [31:0] lmd;
    logic [31:0] hi;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   stalls;

  mem_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .IR_in(IR_in), .PC_in(PC_in), .Z_in(Z_in), .Addr_in(Addr_in),
    .IsStall(IsStall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .IR_out(IR_out), .PC_out(PC_out), .Z_out(Z_out), .LMD(LMD), .LMD_hi(LMD_hi),
    .valid_out(valid_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [25:0] rest);
    return {op, rest};
  endfunction

  task automatic drive(input logic [31:0] ir, input logic [29:0] pc, input logic [31:0] z,
                       input logic [31:0] addr);
    IR_in = ir; PC_in = pc; Z_in = z; Addr_in = addr;
  endtask

  task automatic expect_out(input logic [31:0] lmd, input logic [31:0] hi, input logic fault);
    exp_t e;
    e.ir = IR_in; e.pc = PC_in; e.z = Z_in; e.lmd = lmd; e.hi = hi; e.fault = fault;
    sb.push_back(e);
  endtask

  // One memory beat: nwait cycles without ack, then an acked cycle.
  task automatic beat(input int nwait, input logic [31:0] rd);
    for (int i = 0; i < nwait; i++) begin
      if (IsStall) stalls++;
      tick();
    end
    mem_ack = 1'b1; mem_rdata = rd;
    if (IsStall) stalls++;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (!rst && valid_out) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("IR_out", 64'(IR_out), 64'(e.ir));
        chk("PC_out", 64'(PC_out), 64'(e.pc));
        chk("Z_out", 64'(Z_out), 64'(e.z));
        chk("LMD", 64'(LMD), 64'(e.lmd));
        chk("LMD_hi", 64'(LMD_hi), 64'(e.hi));
        chk("fault_out", 64'(fault_out), 64'(e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive('0, '0, '0, '0);
    tick(); tick();
    chk("rst_IsStall", 64'(IsStall), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_outs", {IR_out, Z_out} | 64'(PC_out) | 64'(LMD) | 64'(LMD_hi) | 64'(fault_out), 64'd0);

    // Reset in the middle of an LW access; this LW never retires.
    drive(mk_ir(OP_LW, 26'h1), 30'h40, 32'h9, 32'h100);
    rst = 1'b0;
    tick();
    chk("acc0_mem_req", 64'(mem_req), 64'd1);
    chk("acc0_IsStall", 64'(IsStall), 64'd1);
    chk("acc0_addr", 64'(mem_addr), 64'h100);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_IsStall", 64'(IsStall), 64'd0);
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_IR_out", 64'(IR_out), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    drive(mk_ir(OP_ADD, 26'h2), 30'h41, 32'h5, 32'h0);
    expect_out('0, '0, 1'b0);
    rst = 1'b0;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("add_valid", 64'(valid_out), 64'd1);
    chk("add_Z_out", 64'(Z_out), 64'h5);
    chk("add_IsStall", 64'(IsStall), 64'd0);

    // LW with two wait cycles.
    drive(mk_ir(OP_LW, 26'h3), 30'h42, 32'h77, 32'h100);
    expect_out(32'hDEADBEEF, '0, 1'b0);
    tick();
    chk("lw_be", 64'(mem_be), 64'hF);
    chk("lw_we", 64'(mem_we), 64'd0);
    chk("lw_addr", 64'(mem_addr), 64'h100);
    stalls = 0;
    beat(2, 32'hDEADBEEF);
    chk("lw_stalls", 64'(stalls), 64'd3);
    chk("lw_IsStall_end", 64'(IsStall), 64'd0);
    chk("lw_valid", 64'(valid_out), 64'd1);
    chk("lw_LMD", 64'(LMD), 64'hDEADBEEF);

    // LH from the upper halfword.
    drive(mk_ir(OP_LH, 26'h4), 30'h43, 32'h12, 32'h102);
    expect_out(32'hFFFF8001, '0, 1'b0);
    tick();
    chk("lw_valid_pulse", 64'(valid_out), 64'd0);
    chk("lh_be", 64'(mem_be), 64'hC);
    chk("lh_we", 64'(mem_we), 64'd0);
    chk("lh_addr", 64'(mem_addr), 64'h100);
    stalls = 0;
    beat(0, 32'h80011234);
    chk("lh_stalls", 64'(stalls), 64'd1);
    chk("lh_LMD", 64'(LMD), 64'hFFFF8001);

    // SH to the lower halfword.
    drive(mk_ir(OP_SH, 26'h5), 30'h44, 32'h0000ABCD, 32'h100);
    expect_out('0, '0, 1'b0);
    tick();
    chk("sh_we", 64'(mem_we), 64'd1);
    chk("sh_be", 64'(mem_be), 64'h3);
    chk("sh_wdata", 64'(mem_wdata), 64'hABCDABCD);
    beat(0, '0);

    // SW with one wait cycle.
    drive(mk_ir(OP_SW, 26'h6), 30'h45, 32'h13572468, 32'h10C);
    expect_out('0, '0, 1'b0);
    tick();
    chk("sw_wdata", 64'(mem_wdata), 64'h13572468);
    chk("sw_addr", 64'(mem_addr), 64'h10C);
    stalls = 0;
    beat(1, '0);
    chk("sw_stalls", 64'(stalls), 64'd2);

    // LD wrapping around the top of the address space.
    drive(mk_ir(OP_LD, 26'h7), 30'h46, 32'h99, 32'hFFFFFFFC);
    expect_out(32'h11, 32'h22, 1'b0);
    tick();
    chk("ld_addr0", 64'(mem_addr), 64'hFFFFFFFC);
    chk("ld_be0", 64'(mem_be), 64'hF);
    stalls = 0;
    beat(0, 32'h11);
    chk("ld_req_beat1", 64'(mem_req), 64'd1);
    chk("ld_addr1", 64'(mem_addr), 64'h0);
    chk("ld_valid_mid", 64'(valid_out), 64'd0);
    beat(0, 32'h22);
    chk("ld_stalls", 64'(stalls), 64'd2);
    chk("ld_LMD_hi", 64'(LMD_hi), 64'h22);

    // SD with negative data: second beat is all ones.
    drive(mk_ir(OP_SD, 26'h8), 30'h47, 32'h80000000, 32'h200);
    expect_out('0, '0, 1'b0);
    tick();
    chk("sd_wdata0", 64'(mem_wdata), 64'h80000000);
    chk("sd_we0", 64'(mem_we), 64'd1);
    beat(0, '0);
    chk("sd_addr1", 64'(mem_addr), 64'h204);
    chk("sd_wdata1", 64'(mem_wdata), 64'hFFFFFFFF);
    chk("sd_be1", 64'(mem_be), 64'hF);
    beat(0, '0);

    // Misaligned accesses fault without a request.
    drive(mk_ir(OP_LW, 26'h9), 30'h48, 32'h31, 32'h102);
    expect_out('0, '0, 1'b1);
    tick();
    chk("mis_lw_req", 64'(mem_req), 64'd0);
    chk("mis_lw_stall", 64'(IsStall), 64'd0);
    chk("mis_lw_fault", {63'd0, fault_out} | {62'd0, valid_out, 1'b0}, 64'd3);
    drive(mk_ir(OP_SH, 26'hA), 30'h49, 32'h32, 32'h101);
    expect_out('0, '0, 1'b1);
    tick();
    chk("mis_sh_req", 64'(mem_req), 64'd0);
    chk("mis_sh_fault", 64'(fault_out), 64'd1);

    // Stray acks while idle, interleaved with non-memory ops.
    for (int i = 0; i < 6; i++) begin
      logic [5:0] op;
      op = (i % 3 == 0) ? OP_ADD : ((i % 3 == 1) ? OP_NOP : OP_HALT);
      drive(mk_ir(op, 26'(i * 37 + 11)), 30'(32'h100 + i), $urandom, $urandom);
      expect_out('0, '0, 1'b0);
      mem_ack = (i % 2 == 0); mem_rdata = $urandom;
      tick();
      chk("stray_req", 64'(mem_req), 64'd0);
      chk("stray_valid", 64'(valid_out), 64'd1);
      chk("stray_stall", 64'(IsStall), 64'd0);
    end
    mem_ack = 1'b0;

    @(negedge clk);
    #1 rst = 1'b1;
    tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
